fire_expand_sequencer: RTL and testbench

Per-layer controller that sequences one fire-module expand datapath (1x1 or 3x3 MAC array with a shared input pixel bus) across a full output feature map. It issues input-feature-map RAM reads, drives the datapath layer enable, waits for the datapath's per-pixel sample strobe, and hands each finished output pixel to the write-back RAM through a req/ack handshake. It sits between the top-level layer scheduler (start/done) and one expand instance plus its input and output RAMs.

---
 rtl/fire_expand_sequencer.sv | 150 +++++++++++++++
 tb/tb_fire_expand_sequencer.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fire_expand_sequencer.sv
// Layer controller for one fire-module expand datapath: streams input-map reads per output
// pixel, waits for the datapath sample strobe, then hands the pixel to write-back via req/ack.
module fire_expand_sequencer #(
   parameter int WOUT           = 8,
   parameter int CHIN           = 112,
   parameter int KERNEL_DIM     = 1,
   parameter int SAMPLE_TIMEOUT = 16,
   parameter int ADDR_W         = $clog2(WOUT*WOUT*KERNEL_DIM*KERNEL_DIM*CHIN),
   parameter int PIX_W          = $clog2(WOUT*WOUT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   output logic              ifm_rd_en_o,
   output logic [ADDR_W-1:0] ifm_rd_addr_o,
   output logic              layer_en_o,
   input  logic              sample_i,
   output logic              wb_req_o,
   output logic [PIX_W-1:0]  wb_pix_o,
   input  logic              wb_ack_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   localparam int NPIX  = WOUT*WOUT;
   localparam int TAPS  = KERNEL_DIM*KERNEL_DIM*CHIN;
   localparam int CH_W  = $clog2(TAPS+1);
   localparam int TMR_W = $clog2(SAMPLE_TIMEOUT+1);

   typedef enum logic [2:0] {IDLE, STREAM, FLUSH, WAIT_SAMPLE, WRITEBACK, DONE} state_t;

   state_t            state_q, state_d;
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              err_q, err_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              layer_en_q, layer_en_d;
   logic              wb_req_q, wb_req_d;
   logic [PIX_W-1:0]  wb_pix_q, wb_pix_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   always_comb begin
      state_d = state_q;
      pix_d   = pix_q;
      ch_d    = ch_q;
      base_d  = base_q;
      timer_d = timer_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = STREAM;
               pix_d   = '0;
               ch_d    = '0;
               base_d  = '0;
               err_d   = 1'b0;
            end
         end
         STREAM: begin
            if (ch_q == CH_W'(TAPS-1)) state_d = FLUSH;
            else                       ch_d    = ch_q + 1'b1;
         end
         FLUSH: begin
            state_d = WAIT_SAMPLE;
            timer_d = '0;
         end
         WAIT_SAMPLE: begin
            // A sample arriving on the last allowed cycle still beats the timeout
            if (sample_i) begin
               state_d = WRITEBACK;
            end else if (timer_q == TMR_W'(SAMPLE_TIMEOUT-1)) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         WRITEBACK: begin
            if (wb_ack_i) begin
               if (pix_q == PIX_W'(NPIX-1)) begin
                  state_d = DONE;
               end else begin
                  pix_d   = pix_q + 1'b1;
                  base_d  = base_q + ADDR_W'(TAPS);
                  ch_d    = '0;
                  state_d = STREAM;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they line up with the state register
      rd_en_d    = (state_d == STREAM);
      rd_addr_d  = rd_en_d ? (base_d + ADDR_W'(ch_d)) : '0;
      layer_en_d = (state_d == STREAM) || (state_d == FLUSH);
      wb_req_d   = (state_d == WRITEBACK);
      wb_pix_d   = wb_req_d ? pix_d : '0;
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pix_q      <= '0;
         ch_q       <= '0;
         base_q     <= '0;
         timer_q    <= '0;
         err_q      <= 1'b0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         layer_en_q <= 1'b0;
         wb_req_q   <= 1'b0;
         wb_pix_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pix_q      <= pix_d;
         ch_q       <= ch_d;
         base_q     <= base_d;
         timer_q    <= timer_d;
         err_q      <= err_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         layer_en_q <= layer_en_d;
         wb_req_q   <= wb_req_d;
         wb_pix_q   <= wb_pix_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign ifm_rd_en_o   = rd_en_q;
   assign ifm_rd_addr_o = rd_addr_q;
   assign layer_en_o    = layer_en_q;
   assign wb_req_o      = wb_req_q;
   assign wb_pix_o      = wb_pix_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_fire_expand_sequencer.sv
// Bench for fire_expand_sequencer: a datapath/write-back responder with per-pixel delays and
// a reference model built from the layer's address, pixel and cycle-count rules.
module tb_fire_expand_sequencer;

   localparam int NPIX   = 64;
   localparam int TAPS   = 112;
   localparam int AW     = $clog2(NPIX*TAPS);
   localparam int PW     = $clog2(NPIX);
   localparam int S_NPIX = 4;
   localparam int S_TAPS = 18;
   localparam int S_AW   = $clog2(S_NPIX*S_TAPS);
   localparam int S_PW   = $clog2(S_NPIX);
   localparam int NEVER  = 255;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_i = 1'b0, sample_i = 1'b0, wb_ack_i = 1'b0;
   logic          ifm_rd_en_o, layer_en_o, wb_req_o, busy_o, done_o, err_o;
   logic [AW-1:0] ifm_rd_addr_o;
   logic [PW-1:0] wb_pix_o;

   logic            s_start = 1'b0, s_sample = 1'b0, s_ack = 1'b0;
   logic            s_rd_en, s_layer_en, s_req, s_busy, s_done, s_err;
   logic [S_AW-1:0] s_addr;
   logic [S_PW-1:0] s_pix;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   fire_expand_sequencer dut (
      .clk(clk), .rst(rst), .start_i(start_i),
      .ifm_rd_en_o(ifm_rd_en_o), .ifm_rd_addr_o(ifm_rd_addr_o), .layer_en_o(layer_en_o),
      .sample_i(sample_i), .wb_req_o(wb_req_o), .wb_pix_o(wb_pix_o), .wb_ack_i(wb_ack_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   fire_expand_sequencer #(.WOUT(2), .CHIN(2), .KERNEL_DIM(3)) dut_k3 (
      .clk(clk), .rst(rst), .start_i(s_start),
      .ifm_rd_en_o(s_rd_en), .ifm_rd_addr_o(s_addr), .layer_en_o(s_layer_en),
      .sample_i(s_sample), .wb_req_o(s_req), .wb_pix_o(s_pix), .wb_ack_i(s_ack),
      .busy_o(s_busy), .done_o(s_done), .err_o(s_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Per-pixel sample delay (cycles into the wait) and ack delay (cycles into the request)
   int sd[NPIX];
   int ad[NPIX];
   bit spurious = 1'b0;
   int cur_pix = 0, wait_cnt = 0, req_cnt = 0;
   bit in_wait = 1'b0;

   always @(negedge clk) begin
      sample_i = 1'b0;
      wb_ack_i = 1'b0;
      if (spurious && ifm_rd_en_o) begin
         sample_i = ($urandom_range(0, 1) == 1);
         wb_ack_i = ($urandom_range(0, 1) == 1);
      end
      if (ifm_rd_en_o) cur_pix = int'(ifm_rd_addr_o) / TAPS;
      if (!busy_o) begin
         in_wait = 1'b0;
      end else if (in_wait) begin
         if (wait_cnt == sd[cur_pix]) begin
            sample_i = 1'b1;
            in_wait  = 1'b0;
         end else begin
            wait_cnt++;
         end
      end
      if (layer_en_o && !ifm_rd_en_o) begin
         in_wait  = 1'b1;
         wait_cnt = 0;
      end
      if (wb_req_o) begin
         if (req_cnt == ad[int'(wb_pix_o)]) begin
            wb_ack_i = 1'b1;
            req_cnt  = 0;
         end else begin
            req_cnt++;
         end
      end else begin
         req_cnt = 0;
      end
   end

   int rd_q[$];
   int wb_q[$];
   int len_q[$];
   int first_rd_cyc, first_busy_cyc, done_cyc, err_cyc, last_flush_cyc;
   int done_cnt, overlap_cnt, unstable_cnt, req_len, prev_pix, start_cyc;
   bit prev_req, prev_err;

   always @(negedge clk) begin
      if (ifm_rd_en_o) begin
         rd_q.push_back(int'(ifm_rd_addr_o));
         if (first_rd_cyc < 0) first_rd_cyc = cyc;
         if (wb_req_o) overlap_cnt++;
      end
      if (busy_o && first_busy_cyc < 0) first_busy_cyc = cyc;
      if (layer_en_o && !ifm_rd_en_o) last_flush_cyc = cyc;
      if (wb_req_o) begin
         if (!prev_req) begin
            wb_q.push_back(int'(wb_pix_o));
            req_len = 0;
         end else if (int'(wb_pix_o) != prev_pix) begin
            unstable_cnt++;
         end
         req_len++;
      end else if (prev_req) begin
         len_q.push_back(req_len);
      end
      if (done_o) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (err_o && !prev_err) err_cyc = cyc;
      prev_req = wb_req_o;
      prev_pix = int'(wb_pix_o);
      prev_err = err_o;
   end

   int s_rd_q[$];
   int s_wb_q[$];
   int s_first_rd = -1, s_done_cyc = -1, s_done_cnt = 0;
   bit s_flush_prev = 1'b0, s_req_prev = 1'b0;

   always @(negedge clk) begin
      s_sample     = s_flush_prev;
      s_flush_prev = s_layer_en && !s_rd_en;
      s_ack        = s_req;
      if (s_rd_en) begin
         s_rd_q.push_back(int'(s_addr));
         if (s_first_rd < 0) s_first_rd = cyc;
      end
      if (s_req && !s_req_prev) s_wb_q.push_back(int'(s_pix));
      s_req_prev = s_req;
      if (s_done) begin
         s_done_cnt++;
         s_done_cyc = cyc;
      end
   end

   task automatic clear_mon();
      rd_q.delete(); wb_q.delete(); len_q.delete();
      first_rd_cyc = -1; first_busy_cyc = -1; done_cyc = -1; err_cyc = -1; last_flush_cyc = -1;
      done_cnt = 0; overlap_cnt = 0; unstable_cnt = 0; req_len = 0;
   endtask

   task automatic zero_delays();
      for (int p = 0; p < NPIX; p++) begin
         sd[p] = 0;
         ad[p] = 0;
      end
   endtask

   task automatic run_layer(input int limit, output bit ok);
      int n;
      @(negedge clk);
      clear_mon();
      start_cyc = cyc;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      ok = 1'b0;
      n = 0;
      while (!ok && n < limit) begin
         if (done_o) ok = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({ifm_rd_en_o, layer_en_o, wb_req_o, busy_o, done_o, err_o} !== 6'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b expected 000000",
                  {ifm_rd_en_o, layer_en_o, wb_req_o, busy_o, done_o, err_o});
      end
      checks++;
      if (ifm_rd_addr_o !== '0 || wb_pix_o !== '0) begin
         errors++;
         $display("[TB] FAIL reset_buses: got addr=%0d pix=%0d expected 0/0", ifm_rd_addr_o, wb_pix_o);
      end
      checks++;
      if ({s_rd_en, s_busy, s_done, s_err} !== 4'b0) begin
         errors++;
         $display("[TB] FAIL reset_k3: got %b expected 0000", {s_rd_en, s_busy, s_done, s_err});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_layer();
      bit ok;
      int bad;
      zero_delays();
      run_layer(20000, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL full_done_timeout: got no done expected done"); end
      checks++;
      if (first_rd_cyc != start_cyc + 1 || first_busy_cyc != first_rd_cyc) begin
         errors++;
         $display("[TB] FAIL full_first_read: got rd=%0d busy=%0d expected %0d", first_rd_cyc, first_busy_cyc, start_cyc + 1);
      end
      bad = 0;
      foreach (rd_q[i]) if (rd_q[i] != i) bad++;
      checks++;
      if (rd_q.size() != NPIX*TAPS || bad != 0) begin
         errors++;
         $display("[TB] FAIL full_reads: got %0d reads %0d out of order expected %0d in order", rd_q.size(), bad, NPIX*TAPS);
      end
      bad = 0;
      foreach (wb_q[i]) if (wb_q[i] != i) bad++;
      foreach (len_q[i]) if (len_q[i] != 1) bad++;
      checks++;
      if (wb_q.size() != NPIX || bad != 0) begin
         errors++;
         $display("[TB] FAIL full_writebacks: got %0d pulses %0d bad expected %0d good", wb_q.size(), bad, NPIX);
      end
      checks++;
      if (done_cyc - first_rd_cyc != NPIX*(TAPS+3) || done_cnt != 1) begin
         errors++;
         $display("[TB] FAIL full_latency: got %0d cycles %0d dones expected %0d cycles 1 done", done_cyc - first_rd_cyc, done_cnt, NPIX*(TAPS+3));
      end
      checks++;
      if (err_o !== 1'b0 || busy_o !== 1'b0 || overlap_cnt != 0) begin
         errors++;
         $display("[TB] FAIL full_end_state: got err=%b busy=%b overlap=%0d expected 0/0/0", err_o, busy_o, overlap_cnt);
      end
   endtask

   task automatic test_kernel3();
      int n, bad;
      @(negedge clk);
      s_rd_q.delete(); s_wb_q.delete();
      s_first_rd = -1; s_done_cyc = -1; s_done_cnt = 0;
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      n = 0;
      while (s_busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      bad = 0;
      foreach (s_rd_q[i]) if (s_rd_q[i] != i) bad++;
      checks++;
      if (s_rd_q.size() != S_NPIX*S_TAPS || bad != 0) begin
         errors++;
         $display("[TB] FAIL k3_reads: got %0d reads %0d bad expected %0d", s_rd_q.size(), bad, S_NPIX*S_TAPS);
      end
      for (int p = 0; p < S_NPIX; p++) begin
         checks++;
         if (s_rd_q.size() <= p*S_TAPS || s_rd_q[p*S_TAPS] != p*S_TAPS) begin
            errors++;
            $display("[TB] FAIL k3_base: pixel %0d got base %0d expected %0d", p,
                     (s_rd_q.size() > p*S_TAPS) ? s_rd_q[p*S_TAPS] : -1, p*S_TAPS);
         end
      end
      checks++;
      if (s_wb_q.size() != S_NPIX || s_done_cnt != 1) begin
         errors++;
         $display("[TB] FAIL k3_writebacks: got %0d wb %0d done expected %0d wb 1 done", s_wb_q.size(), s_done_cnt, S_NPIX);
      end
      checks++;
      if (s_done_cyc - s_first_rd != S_NPIX*(S_TAPS+3)) begin
         errors++;
         $display("[TB] FAIL k3_latency: got %0d expected %0d", s_done_cyc - s_first_rd, S_NPIX*(S_TAPS+3));
      end
   endtask

   task automatic test_ack_delay();
      bit ok;
      int bad, total;
      total = 0;
      for (int p = 0; p < NPIX; p++) begin
         sd[p] = $urandom_range(0, 14);
         ad[p] = $urandom_range(0, 3);
      end
      ad[3] = 5;
      sd[7] = 15;
      for (int p = 0; p < NPIX; p++) total += TAPS + 3 + sd[p] + ad[p];
      run_layer(20000, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL ack_done_timeout: got no done expected done"); end
      checks++;
      if (len_q.size() < 4 || len_q[3] != 6 || unstable_cnt != 0 || overlap_cnt != 0) begin
         errors++;
         $display("[TB] FAIL ack_hold_pix3: got len=%0d unstable=%0d overlap=%0d expected 6/0/0",
                  (len_q.size() > 3) ? len_q[3] : -1, unstable_cnt, overlap_cnt);
      end
      bad = 0;
      foreach (len_q[i]) if (len_q[i] != ad[i] + 1) bad++;
      foreach (wb_q[i]) if (wb_q[i] != i) bad++;
      checks++;
      if (wb_q.size() != NPIX || bad != 0) begin
         errors++;
         $display("[TB] FAIL ack_writebacks: got %0d pulses %0d bad expected %0d good", wb_q.size(), bad, NPIX);
      end
      bad = 0;
      foreach (rd_q[i]) if (rd_q[i] != i) bad++;
      checks++;
      if (rd_q.size() != NPIX*TAPS || bad != 0 || rd_q[4*TAPS] != 4*TAPS) begin
         errors++;
         $display("[TB] FAIL ack_reads: got %0d reads %0d bad expected %0d in order", rd_q.size(), bad, NPIX*TAPS);
      end
      checks++;
      if (done_cyc - first_rd_cyc != total || err_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ack_latency: got %0d cycles err=%b expected %0d cycles err=0", done_cyc - first_rd_cyc, err_o, total);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      zero_delays();
      sd[10] = NEVER;
      run_layer(20000, ok);
      checks++;
      if (!ok || done_cnt != 1 || busy_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL tmo_done: got ok=%0d dones=%0d busy=%b expected 1/1/0", ok, done_cnt, busy_o);
      end
      checks++;
      if (rd_q.size() != 11*TAPS || wb_q.size() != 10) begin
         errors++;
         $display("[TB] FAIL tmo_progress: got %0d reads %0d wb expected %0d reads 10 wb", rd_q.size(), wb_q.size(), 11*TAPS);
      end
      checks++;
      if (err_cyc - last_flush_cyc != 17 || done_cyc != err_cyc) begin
         errors++;
         $display("[TB] FAIL tmo_timing: got err at flush+%0d done at %0d expected flush+17 done at %0d", err_cyc - last_flush_cyc, done_cyc, err_cyc);
      end
      checks++;
      if (err_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL tmo_sticky: got err=%b expected 1", err_o);
      end
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      checks++;
      if (err_o !== 1'b0 || ifm_rd_en_o !== 1'b1 || ifm_rd_addr_o !== '0) begin
         errors++;
         $display("[TB] FAIL tmo_restart: got err=%b rd=%b addr=%0d expected 0/1/0", err_o, ifm_rd_en_o, ifm_rd_addr_o);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      zero_delays();
   endtask

   task automatic test_spurious();
      bit ok;
      int n, bad;
      zero_delays();
      spurious = 1'b1;
      @(negedge clk);
      clear_mon();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      ok = 1'b0;
      n = 0;
      while (!ok && n < 20000) begin
         if (done_o) ok = 1'b1;
         else begin
            start_i = ifm_rd_en_o && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            n++;
         end
      end
      start_i = 1'b0;
      spurious = 1'b0;
      @(negedge clk);
      bad = 0;
      foreach (rd_q[i]) if (rd_q[i] != i) bad++;
      foreach (wb_q[i]) if (wb_q[i] != i) bad++;
      checks++;
      if (!ok || rd_q.size() != NPIX*TAPS || wb_q.size() != NPIX || bad != 0) begin
         errors++;
         $display("[TB] FAIL spur_sequence: got ok=%0d reads=%0d wb=%0d bad=%0d expected 1/%0d/%0d/0", ok, rd_q.size(), wb_q.size(), bad, NPIX*TAPS, NPIX);
      end
      checks++;
      if (done_cyc - first_rd_cyc != NPIX*(TAPS+3) || done_cnt != 1 || err_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL spur_latency: got %0d cycles %0d dones err=%b expected %0d/1/0", done_cyc - first_rd_cyc, done_cnt, err_o, NPIX*(TAPS+3));
      end
   endtask

   task automatic test_reset_mid();
      int n, bad;
      zero_delays();
      @(negedge clk);
      clear_mon();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      n = 0;
      while (rd_q.size() < 5*TAPS + 20 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (ifm_rd_en_o !== 1'b1 || int'(ifm_rd_addr_o) / TAPS != 5) begin
         errors++;
         $display("[TB] FAIL mid_position: got rd=%b addr=%0d expected streaming pixel 5", ifm_rd_en_o, ifm_rd_addr_o);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({ifm_rd_en_o, layer_en_o, wb_req_o, busy_o, done_o, err_o} !== 6'b0 || ifm_rd_addr_o !== '0) begin
         errors++;
         $display("[TB] FAIL mid_reset_outputs: got %b addr=%0d expected 000000 addr=0",
                  {ifm_rd_en_o, layer_en_o, wb_req_o, busy_o, done_o, err_o}, ifm_rd_addr_o);
      end
      rst = 1'b0;
      @(negedge clk);
      clear_mon();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      n = 0;
      while (wb_q.size() < 1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < TAPS && i < rd_q.size(); i++) if (rd_q[i] != i) bad++;
      checks++;
      if (rd_q.size() < TAPS || bad != 0 || wb_q.size() < 1 || wb_q[0] != 0) begin
         errors++;
         $display("[TB] FAIL mid_restart: got reads=%0d bad=%0d wb=%0d expected >=%0d/0/pixel 0", rd_q.size(), bad, wb_q.size(), TAPS);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      zero_delays();
      clear_mon();
      test_reset();
      test_full_layer();
      test_kernel3();
      test_ack_delay();
      test_timeout();
      test_spurious();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
